// File: rtl/fix_msg_parse_pkg.sv
// Shared byte constants, parser state encoding and helpers for the FIX receive parser.
package fix_msg_parse_pkg;

    localparam int VALUE_DATA_WIDTH = 64;

    localparam logic [7:0] SOH       = 8'h01;
    localparam logic [7:0] EQ        = 8'h3d;
    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] CSUM_TAG0 = 8'h31;
    localparam logic [7:0] CSUM_TAG1 = 8'h30;

    // One-hot parser states
    localparam logic [3:0] S_TAG     = 4'b0001;
    localparam logic [3:0] S_VAL     = 4'b0010;
    localparam logic [3:0] S_CSUM    = 4'b0100;
    localparam logic [3:0] S_DISCARD = 4'b1000;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

endpackage

// File: rtl/fix_field_acc.sv
// Byte accumulator: packs bytes little-end first, keeps a thermometer byte count
// and flags a push that arrives when already full.
module fix_field_acc #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push,
    input  logic [7:0]         next_byte,
    output logic [8*BYTES-1:0] packed_bytes,
    output logic [BYTES-1:0]   size,
    output logic               empty,
    output logic               overflow
);

    logic [BYTES-1:0] slot;

    // The single bit that turns on with the next push marks the write lane
    assign slot     = size ^ {size[BYTES-2:0], 1'b1};
    assign empty    = ~size[0];
    assign overflow = push & size[BYTES-1];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            packed_bytes <= '0;
            size         <= '0;
        end else if (push && !size[BYTES-1]) begin
            for (int i = 0; i < BYTES; i++) begin
                if (slot[i]) begin
                    packed_bytes[i*8 +: 8] <= next_byte;
                end
            end
            size <= {size[BYTES-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/fix_msg_parse.sv
// FIX receive parser: splits a tag=value<SOH> byte stream into packed tag/value
// words and checks the 10=ddd trailer against the running byte sum.
module fix_msg_parse
    import fix_msg_parse_pkg::*;
#(
    parameter int VALUE_WIDTH = VALUE_DATA_WIDTH,
    parameter int TAG_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data_i,
    input  logic                     data_valid_i,
    output logic [8*TAG_BYTES-1:0]   tag_o,
    output logic [TAG_BYTES-1:0]     t_size_o,
    output logic                     tag_valid_o,
    output logic [VALUE_WIDTH-1:0]   val_o,
    output logic [VALUE_WIDTH/8-1:0] v_size_o,
    output logic                     val_valid_o,
    output logic                     end_of_msg_o,
    output logic                     checksum_ok_o,
    output logic                     checksum_err_o,
    output logic [7:0]               checksum_val_o,
    output logic                     field_err_o
);

    localparam int VAL_BYTES = VALUE_WIDTH / 8;

    logic [3:0] state, next_state;
    logic       from_csum, next_from_csum;
    logic [7:0] sum, sum_field_start;
    logic       sticky;
    logic [1:0] digit_cnt;
    logic [9:0] recv;
    logic [7:0] digit_val;

    logic                   tag_push, tag_clr, tag_empty, tag_ovf;
    logic [8*TAG_BYTES-1:0] tag_data;
    logic [TAG_BYTES-1:0]   tag_therm;
    logic                   val_push, val_clr, val_empty, val_ovf;
    logic [VALUE_WIDTH-1:0] val_data;
    logic [VAL_BYTES-1:0]   val_therm;

    logic ev_tag, ev_val, ev_err, ev_end, ev_end_ok;
    logic digit_push, digit_clr, is_csum_tag;

    fix_field_acc #(.BYTES(TAG_BYTES)) u_tag_acc (
        .clk(clk), .rst(rst), .clr(tag_clr), .push(tag_push), .next_byte(data_i),
        .packed_bytes(tag_data), .size(tag_therm), .empty(tag_empty), .overflow(tag_ovf)
    );

    fix_field_acc #(.BYTES(VAL_BYTES)) u_val_acc (
        .clk(clk), .rst(rst), .clr(val_clr), .push(val_push), .next_byte(data_i),
        .packed_bytes(val_data), .size(val_therm), .empty(val_empty), .overflow(val_ovf)
    );

    assign digit_val   = data_i - ASCII_0;
    assign is_csum_tag = (tag_therm == {{(TAG_BYTES-2){1'b0}}, 2'b11}) &&
                         (tag_data[15:0] == {CSUM_TAG1, CSUM_TAG0});

    // Decode the consumed byte against the current state into field events
    always_comb begin
        next_state     = state;
        next_from_csum = from_csum;
        tag_push = 1'b0;  tag_clr = 1'b0;
        val_push = 1'b0;  val_clr = 1'b0;
        ev_tag = 1'b0;  ev_val = 1'b0;  ev_err = 1'b0;
        ev_end = 1'b0;  ev_end_ok = 1'b0;
        digit_push = 1'b0;  digit_clr = 1'b0;
        if (data_valid_i) begin
            case (state)
                S_TAG: begin
                    if (data_i == EQ) begin
                        tag_clr = 1'b1;
                        if (tag_empty) begin
                            ev_err = 1'b1;  next_state = S_DISCARD;  next_from_csum = 1'b0;
                        end else if (is_csum_tag) begin
                            digit_clr = 1'b1;  next_state = S_CSUM;
                        end else begin
                            ev_tag = 1'b1;  next_state = S_VAL;
                        end
                    end else begin
                        tag_push = (data_i != SOH);
                        if (data_i == SOH || tag_ovf) begin
                            tag_clr = 1'b1;  ev_err = 1'b1;
                            next_state = S_DISCARD;  next_from_csum = 1'b0;
                        end
                    end
                end
                S_VAL: begin
                    if (data_i == SOH) begin
                        val_clr = 1'b1;  next_state = S_TAG;
                        if (val_empty) begin
                            ev_err = 1'b1;  next_state = S_DISCARD;  next_from_csum = 1'b0;
                        end else begin
                            ev_val = 1'b1;
                        end
                    end else begin
                        val_push = 1'b1;
                        if (val_ovf) begin
                            val_clr = 1'b1;  ev_err = 1'b1;
                            next_state = S_DISCARD;  next_from_csum = 1'b0;
                        end
                    end
                end
                S_CSUM: begin
                    if (data_i == SOH) begin
                        ev_end = 1'b1;  next_state = S_TAG;
                        if (digit_cnt == 2'd3) begin
                            ev_end_ok = (recv == {2'b00, sum_field_start}) && !sticky;
                        end else begin
                            ev_err = 1'b1;
                        end
                    end else if (is_digit(data_i) && digit_cnt != 2'd3) begin
                        digit_push = 1'b1;
                    end else begin
                        ev_err = 1'b1;  next_state = S_DISCARD;  next_from_csum = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (data_i == SOH) begin
                        ev_end = from_csum;  next_state = S_TAG;  next_from_csum = 1'b0;
                    end
                end
                default: next_state = S_TAG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_TAG;
            from_csum       <= 1'b0;
            sum             <= '0;
            sum_field_start <= '0;
            sticky          <= 1'b0;
            digit_cnt       <= '0;
            recv            <= '0;
            tag_o           <= '0;
            t_size_o        <= '0;
            tag_valid_o     <= 1'b0;
            val_o           <= '0;
            v_size_o        <= '0;
            val_valid_o     <= 1'b0;
            end_of_msg_o    <= 1'b0;
            checksum_ok_o   <= 1'b0;
            checksum_err_o  <= 1'b0;
            checksum_val_o  <= '0;
            field_err_o     <= 1'b0;
        end else begin
            state        <= next_state;
            from_csum    <= next_from_csum;
            tag_valid_o  <= ev_tag;
            val_valid_o  <= ev_val;
            field_err_o  <= ev_err;
            end_of_msg_o <= ev_end;
            if (ev_tag) begin
                tag_o    <= tag_data;
                t_size_o <= tag_therm;
            end
            if (ev_val) begin
                val_o    <= val_data;
                v_size_o <= val_therm;
            end
            if (ev_end) begin
                checksum_ok_o  <= ev_end_ok;
                checksum_err_o <= !ev_end_ok;
                checksum_val_o <= sum_field_start;
            end
            // The trailer restarts the running sum so the next message sums from zero
            if (data_valid_i) begin
                sum <= ev_end ? 8'h00 : sum + data_i;
                if (state == S_TAG && tag_empty) begin
                    sum_field_start <= sum;
                end
            end
            if (ev_end) begin
                sticky <= 1'b0;
            end else if (ev_err) begin
                sticky <= 1'b1;
            end
            if (digit_clr) begin
                digit_cnt <= '0;
                recv      <= '0;
            end else if (digit_push) begin
                digit_cnt <= digit_cnt + 2'd1;
                recv      <= recv * 10'd10 + {2'b00, digit_val};
            end
        end
    end

endmodule

// File: tb/tb_fix_msg_parse.sv
// Randomized and directed bench for fix_msg_parse, checked against a field-level reference model.
module tb_fix_msg_parse;

    localparam int VW = 64;
    localparam int VB = VW / 8;
    localparam int TB_BYTES = 4;

    localparam int M_TAG  = 0;
    localparam int M_VAL  = 1;
    localparam int M_CSUM = 2;
    localparam int M_DISC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_i;
    logic          data_valid_i;
    logic [31:0]   tag_o;
    logic [3:0]    t_size_o;
    logic          tag_valid_o;
    logic [VW-1:0] val_o;
    logic [VB-1:0] v_size_o;
    logic          val_valid_o;
    logic          end_of_msg_o;
    logic          checksum_ok_o;
    logic          checksum_err_o;
    logic [7:0]    checksum_val_o;
    logic          field_err_o;

    int errors = 0;
    int checks = 0;

    fix_msg_parse #(.VALUE_WIDTH(VW), .TAG_BYTES(TB_BYTES)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .data_valid_i(data_valid_i),
        .tag_o(tag_o), .t_size_o(t_size_o), .tag_valid_o(tag_valid_o),
        .val_o(val_o), .v_size_o(v_size_o), .val_valid_o(val_valid_o),
        .end_of_msg_o(end_of_msg_o), .checksum_ok_o(checksum_ok_o),
        .checksum_err_o(checksum_err_o), .checksum_val_o(checksum_val_o),
        .field_err_o(field_err_o)
    );

    always #5 clk = ~clk;

    // Reference model: field text kept in queues, checksum summed from the stored message
    logic [7:0] fq[$];
    logic [7:0] dq[$];
    logic [7:0] msg_q[$];
    int         mode;
    bit         from_c, sticky;
    logic [7:0] csum_calc;

    logic [31:0]   e_tag;
    logic [3:0]    e_tsize;
    logic          e_tv;
    logic [VW-1:0] e_val;
    logic [VB-1:0] e_vsize;
    logic          e_vv, e_eom, e_ok, e_err, e_ferr;
    logic [7:0]    e_cval;

    task automatic model_reset();
        fq.delete(); dq.delete(); msg_q.delete();
        mode = M_TAG; from_c = 0; sticky = 0; csum_calc = 0;
        e_tag = 0; e_tsize = 0; e_tv = 0; e_val = 0; e_vsize = 0;
        e_vv = 0; e_eom = 0; e_ok = 0; e_err = 0; e_ferr = 0; e_cval = 0;
    endtask

    task automatic model_idle();
        e_tv = 0; e_vv = 0; e_eom = 0; e_ferr = 0;
    endtask

    task automatic flag_err(input bit fc);
        e_ferr = 1; sticky = 1; mode = M_DISC; from_c = fc;
    endtask

    task automatic trailer_end(input bit ok);
        e_eom = 1; e_ok = ok; e_err = !ok; e_cval = csum_calc;
        sticky = 0; msg_q.delete(); mode = M_TAG;
    endtask

    function automatic int msg_sum();
        int s = 0;
        foreach (msg_q[i]) s += msg_q[i];
        return s % 256;
    endfunction

    task automatic model_step(input logic [7:0] b);
        int s, recv;
        model_idle();
        msg_q.push_back(b);
        case (mode)
            M_TAG: begin
                if (b == 8'h3d) begin
                    if (fq.size() == 0) flag_err(0);
                    else if (fq.size() == 2 && fq[0] == 8'h31 && fq[1] == 8'h30) begin
                        s = 0;
                        for (int i = 0; i < msg_q.size() - 3; i++) s += msg_q[i];
                        csum_calc = 8'(s % 256);
                        dq.delete();
                        mode = M_CSUM;
                    end else begin
                        e_tv = 1; e_tag = 0;
                        foreach (fq[i]) e_tag[i*8 +: 8] = fq[i];
                        e_tsize = 4'((1 << fq.size()) - 1);
                        mode = M_VAL;
                    end
                    fq.delete();
                end else if (b == 8'h01 || fq.size() == TB_BYTES) begin
                    flag_err(0); fq.delete();
                end else fq.push_back(b);
            end
            M_VAL: begin
                if (b == 8'h01) begin
                    if (fq.size() == 0) flag_err(0);
                    else begin
                        e_vv = 1; e_val = 0;
                        foreach (fq[i]) e_val[i*8 +: 8] = fq[i];
                        e_vsize = VB'((1 << fq.size()) - 1);
                        mode = M_TAG;
                    end
                    fq.delete();
                end else if (fq.size() == VB) begin
                    flag_err(0); fq.delete();
                end else fq.push_back(b);
            end
            M_CSUM: begin
                if (b == 8'h01) begin
                    if (dq.size() == 3) begin
                        recv = (dq[0] - 48) * 100 + (dq[1] - 48) * 10 + (dq[2] - 48);
                        trailer_end(recv == int'(csum_calc) && !sticky);
                    end else begin
                        e_ferr = 1;
                        trailer_end(0);
                    end
                end else if (b >= 8'h30 && b <= 8'h39 && dq.size() < 3) dq.push_back(b);
                else flag_err(1);
            end
            default: begin
                if (b == 8'h01) begin
                    if (from_c) trailer_end(0);
                    mode = M_TAG; from_c = 0;
                end
            end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("tag_valid", 64'(tag_valid_o), 64'(e_tv));
        checkOutput("tag", 64'(tag_o), 64'(e_tag));
        checkOutput("t_size", 64'(t_size_o), 64'(e_tsize));
        checkOutput("val_valid", 64'(val_valid_o), 64'(e_vv));
        checkOutput("val", 64'(val_o), 64'(e_val));
        checkOutput("v_size", 64'(v_size_o), 64'(e_vsize));
        checkOutput("end_of_msg", 64'(end_of_msg_o), 64'(e_eom));
        checkOutput("checksum_ok", 64'(checksum_ok_o), 64'(e_ok));
        checkOutput("checksum_err", 64'(checksum_err_o), 64'(e_err));
        checkOutput("checksum_val", 64'(checksum_val_o), 64'(e_cval));
        checkOutput("field_err", 64'(field_err_o), 64'(e_ferr));
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge clk);
        data_i = b; data_valid_i = 1'b1;
        model_step(b);
        @(posedge clk); #1;
        checkAll();
        repeat (gap) begin
            @(negedge clk);
            data_valid_i = 1'b0; data_i = 8'($urandom);
            model_idle();
            @(posedge clk); #1;
            checkAll();
        end
    endtask

    // '|' in stimulus strings stands for SOH
    task automatic sendStr(input string s, input int maxgap);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == 8'h7c) c = 8'h01;
            applyStimulus(c, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; data_valid_i = 1'b0;
        @(posedge clk); #1;
        model_reset();
        checkAll();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cs;
        string s;
        rst = 1'b0; data_i = 8'h00; data_valid_i = 1'b0;
        model_reset();
        doReset();

        sendStr("35=", 0);
        checkOutput("dir_tag_valid", 64'(tag_valid_o), 64'd1);
        checkOutput("dir_tag", 64'(tag_o), 64'h0000_3533);
        checkOutput("dir_t_size", 64'(t_size_o), 64'b0011);
        sendStr("A|", 0);
        checkOutput("dir_val_valid", 64'(val_valid_o), 64'd1);
        checkOutput("dir_val", 64'(val_o[7:0]), 64'h41);
        checkOutput("dir_v_size", 64'(v_size_o), 64'd1);
        sendStr("10=231|", 0);
        checkOutput("dir_eom", 64'(end_of_msg_o), 64'd1);
        checkOutput("dir_csum_ok", 64'(checksum_ok_o), 64'd1);
        checkOutput("dir_csum_val", 64'(checksum_val_o), 64'hE7);

        sendStr("35=A|10=232|", 0);
        checkOutput("dir_csum_err", 64'(checksum_err_o), 64'd1);

        sendStr("=5|35=A|12345=X|35=A|10=000|", 0);
        sendStr("58=ABCDEFGH|", 0);
        checkOutput("dir_v_size_full", 64'(v_size_o), 64'hFF);
        sendStr("58=ABCDEFGHI|35=A|", 0);
        sendStr("10=2x|35=B|10=12|35=C|10=1234|", 0);
        sendStr("35=A|", 1);
        sendStr(": |10=1|", 0);

        sendStr("35=A|35", 0);
        doReset();
        sendStr("35=A|", 2);

        for (int m = 0; m < 40; m++) begin
            for (int f = 0; f < $urandom_range(1, 4); f++) begin
                int tl, vl;
                s = "";
                tl = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(1, 4);
                vl = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 9)
                                                 : $urandom_range(1, 8);
                for (int i = 0; i < tl; i++)
                    s = $sformatf("%s%c", s, (i == 0) ? $urandom_range(50, 57) : $urandom_range(48, 57));
                s = {s, "="};
                for (int i = 0; i < vl; i++)
                    s = $sformatf("%s%c", s, $urandom_range(65, 90));
                s = {s, "|"};
                sendStr(s, ($urandom_range(0, 1) == 0) ? 0 : 2);
            end
            cs = msg_sum();
            if ($urandom_range(0, 4) == 0) cs = (cs + 1) % 256;
            sendStr($sformatf("10=%03d|", cs), ($urandom_range(0, 1) == 0) ? 0 : 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
